// File: rtl/seg7_scan_driver.sv
// Multiplexes a 4-digit packed BCD value onto a shared 7-segment display.
// Snapshots inputs once per frame, with leading-zero blanking, blinking and an error glyph.
module seg7_scan_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int BLINK_DIV  = 50,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Qdata,
  input  logic [3:0]  blink,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int PRE_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(SCAN_DIV - 1);
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(BLINK_DIV - 1);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [1:0]        idx_q, idx_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  logic              primed_q, primed_d;
  logic [15:0]       snap_data_q, snap_data_d;
  logic [3:0]        snap_blink_q, snap_blink_d;
  logic              snap_lz_q, snap_lz_d;
  logic              frame_tick_q, frame_tick_d;
  logic [6:0]        seg_q, seg_d;
  logic [3:0]        an_q, an_d;

  logic              pre_wrap;
  logic              frame_end;

  assign pre_wrap  = (pre_q == PRE_MAX);
  assign frame_end = pre_wrap && (idx_q == 2'd3);

  // Scan timing, frame-end snapshot and blink phase.
  always_comb begin
    pre_d        = pre_wrap ? '0 : pre_q + PRE_W'(1);
    idx_d        = pre_wrap ? idx_q + 2'd1 : idx_q;
    fcnt_d       = fcnt_q;
    phase_d      = phase_q;
    primed_d     = primed_q | frame_end;
    snap_data_d  = snap_data_q;
    snap_blink_d = snap_blink_q;
    snap_lz_d    = snap_lz_q;
    frame_tick_d = frame_end;
    if (frame_end) begin
      snap_data_d  = Qdata;
      snap_blink_d = blink;
      snap_lz_d    = lz_en;
      if (fcnt_q == FCNT_MAX) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  logic [3:0] nib;
  logic [3:0] nib1, nib2, nib3;
  logic       lz_dark;
  logic       blink_dark;
  logic       lit;
  logic [6:0] glyph;
  logic [6:0] seg_hi;
  logic [3:0] an_hi;

  assign nib1 = snap_data_q[7:4];
  assign nib2 = snap_data_q[11:8];
  assign nib3 = snap_data_q[15:12];

  always_comb begin
    nib = snap_data_q[{idx_q, 2'b00} +: 4];
    lz_dark = 1'b0;
    case (idx_q)
      2'd3:    lz_dark = (nib3 == 4'd0);
      2'd2:    lz_dark = (nib3 == 4'd0) && (nib2 == 4'd0);
      2'd1:    lz_dark = (nib3 == 4'd0) && (nib2 == 4'd0) && (nib1 == 4'd0);
      default: lz_dark = 1'b0;
    endcase
    lz_dark    = lz_dark & snap_lz_q;
    blink_dark = snap_blink_q[idx_q] & phase_q;
    lit        = primed_q & ~lz_dark & ~blink_dark;
    case (nib)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h79;
    endcase
    seg_hi = lit ? glyph : 7'h00;
    an_hi  = lit ? (4'b0001 << idx_q) : 4'h0;
    seg_d  = ACTIVE_LOW ? ~seg_hi : seg_hi;
    an_d   = ACTIVE_LOW ? ~an_hi : an_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      idx_q        <= 2'd0;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      primed_q     <= 1'b0;
      snap_data_q  <= 16'h0000;
      snap_blink_q <= 4'h0;
      snap_lz_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
    end else begin
      pre_q        <= pre_d;
      idx_q        <= idx_d;
      fcnt_q       <= fcnt_d;
      phase_q      <= phase_d;
      primed_q     <= primed_d;
      snap_data_q  <= snap_data_d;
      snap_blink_q <= snap_blink_d;
      snap_lz_q    <= snap_lz_d;
      frame_tick_q <= frame_tick_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed vector table, corner sequences,
// and randomized stimulus against a frame-level reference model.
module tb_seg7_scan_driver;

  localparam int SCAN_DIV   = 4;
  localparam int BLINK_DIV  = 2;
  localparam bit ACTIVE_LOW = 1'b1;
  localparam int FRAME      = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] qdata = 16'h0000;
  logic [3:0]  blink = 4'h0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  seg7_scan_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV),
    .ACTIVE_LOW(ACTIVE_LOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Qdata     (qdata),
    .blink     (blink),
    .lz_en     (lz_en),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  logic [6:0] glyph_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};

  // Reference model: k edges since reset, fe frame ends seen so far, inputs latched at frame ends.
  int          m_k = 0;
  int          m_fe = 0;
  logic [15:0] m_snap = 16'h0000;
  logic [3:0]  m_blink = 4'h0;
  logic        m_lz = 1'b0;
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_an = 4'hF;
  logic        exp_tick = 1'b0;
  bit          check_en = 1'b0;

  function automatic logic [10:0] model_out(input int k, input int fe, input logic [15:0] snap,
                                            input logic [3:0] b, input logic lz);
    int         slot;
    logic       dark;
    logic [3:0] nib;
    slot = ((k - 1) / SCAN_DIV) % 4;
    nib  = 4'(snap >> (4 * slot));
    dark = (fe == 0) || (b[slot] && ((fe / BLINK_DIV) % 2 == 1)) ||
           (lz && slot > 0 && (16'(snap >> (4 * slot)) == 16'd0));
    if (dark) return {4'hF, 7'h7F};
    return {~(4'(4'b0001 << slot)), ~glyph_lut[nib]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_k      <= 0;
      m_fe     <= 0;
      m_snap   <= 16'h0000;
      m_blink  <= 4'h0;
      m_lz     <= 1'b0;
      exp_seg  <= 7'h7F;
      exp_an   <= 4'hF;
      exp_tick <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      {exp_an, exp_seg} <= model_out(m_k + 1, m_fe, m_snap, m_blink, m_lz);
      if ((m_k + 1) % FRAME == 0) begin
        m_snap   <= qdata;
        m_blink  <= blink;
        m_lz     <= lz_en;
        m_fe     <= m_fe + 1;
        exp_tick <= 1'b1;
      end else begin
        exp_tick <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_output("model seg", 32'(seg), 32'(exp_seg));
      check_output("model an", 32'(an), 32'(exp_an));
      check_output("model frame_tick", 32'(frame_tick), 32'(exp_tick));
    end
  end

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [3:0]  b;
    logic        lz;
    int          slot;
    logic [6:0]  seg;
    logic [3:0]  an;
  } vec_t;

  vec_t vecs[15];
  int   edge_cnt;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    edge_cnt = 0;
  endtask

  task automatic goto_edge(input int target);
    repeat (target - edge_cnt) @(negedge clk);
    edge_cnt = target;
  endtask

  task automatic apply_stimulus(input vec_t v);
    do_reset();
    qdata = v.q;
    blink = v.b;
    lz_en = v.lz;
    goto_edge(17 + 4 * v.slot);
    check_output({v.name, " seg"}, 32'(seg), 32'(v.seg));
    check_output({v.name, " an"}, 32'(an), 32'(v.an));
  endtask

  initial begin
    vecs[0]  = '{"1234 d0", 16'h1234, 4'h0, 1'b0, 0, 7'h19, 4'b1110};
    vecs[1]  = '{"1234 d1", 16'h1234, 4'h0, 1'b0, 1, 7'h30, 4'b1101};
    vecs[2]  = '{"1234 d2", 16'h1234, 4'h0, 1'b0, 2, 7'h24, 4'b1011};
    vecs[3]  = '{"1234 d3", 16'h1234, 4'h0, 1'b0, 3, 7'h79, 4'b0111};
    vecs[4]  = '{"0070 lz d3", 16'h0070, 4'h0, 1'b1, 3, 7'h7F, 4'hF};
    vecs[5]  = '{"0070 lz d2", 16'h0070, 4'h0, 1'b1, 2, 7'h7F, 4'hF};
    vecs[6]  = '{"0070 lz d1", 16'h0070, 4'h0, 1'b1, 1, 7'h78, 4'b1101};
    vecs[7]  = '{"0070 lz d0", 16'h0070, 4'h0, 1'b1, 0, 7'h40, 4'b1110};
    vecs[8]  = '{"0070 nolz d3", 16'h0070, 4'h0, 1'b0, 3, 7'h40, 4'b0111};
    vecs[9]  = '{"0070 nolz d2", 16'h0070, 4'h0, 1'b0, 2, 7'h40, 4'b1011};
    vecs[10] = '{"00A0 lz d1", 16'h00A0, 4'h0, 1'b1, 1, 7'h06, 4'b1101};
    vecs[11] = '{"00A0 lz d2", 16'h00A0, 4'h0, 1'b1, 2, 7'h7F, 4'hF};
    vecs[12] = '{"00A0 lz d0", 16'h00A0, 4'h0, 1'b1, 0, 7'h40, 4'b1110};
    vecs[13] = '{"0000 lz d0", 16'h0000, 4'h0, 1'b1, 0, 7'h40, 4'b1110};
    vecs[14] = '{"F000 lz d3", 16'hF000, 4'h0, 1'b1, 3, 7'h06, 4'b0111};

    do_reset();
    check_en = 1'b1;
    check_output("reset an", 32'(an), 32'(4'hF));
    check_output("reset seg", 32'(seg), 32'(7'h7F));
    check_output("reset frame_tick", 32'(frame_tick), 32'(1'b0));

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // First frame after reset stays dark; frame_tick follows edge 16.
    do_reset();
    qdata = 16'h1234;
    for (int i = 1; i <= 17; i++) begin
      goto_edge(i);
      check_output($sformatf("prime tick e%0d", i), 32'(frame_tick), 32'(i == 16));
      check_output($sformatf("prime an e%0d", i), 32'(an), 32'((i == 17) ? 4'b1110 : 4'hF));
    end

    // Blink on digit 0 with a two-frame half-period.
    do_reset();
    qdata = 16'h9675;
    blink = 4'b0001;
    for (int f = 1; f <= 5; f++) begin
      goto_edge(17 + FRAME * (f - 1));
      check_output($sformatf("blink d0 an f%0d", f), 32'(an), 32'((f == 2 || f == 3) ? 4'hF : 4'b1110));
      check_output($sformatf("blink d0 seg f%0d", f), 32'(seg), 32'((f == 2 || f == 3) ? 7'h7F : 7'h12));
      goto_edge(21 + FRAME * (f - 1));
      check_output($sformatf("blink d1 an f%0d", f), 32'(an), 32'(4'b1101));
      check_output($sformatf("blink d1 seg f%0d", f), 32'(seg), 32'(7'h78));
    end
    blink = 4'h0;

    // Mid-frame data change must not tear the frame in progress.
    do_reset();
    qdata = 16'h1111;
    goto_edge(24);
    qdata = 16'h2222;
    goto_edge(25);
    check_output("tear d2 seg", 32'(seg), 32'(7'h79));
    check_output("tear d2 an", 32'(an), 32'(4'b1011));
    goto_edge(29);
    check_output("tear d3 seg", 32'(seg), 32'(7'h79));
    goto_edge(33);
    check_output("tear next d0 seg", 32'(seg), 32'(7'h24));
    goto_edge(45);
    check_output("tear next d3 seg", 32'(seg), 32'(7'h24));

    // Reset mid-frame at idx=2, pre=1.
    do_reset();
    qdata = 16'h1234;
    goto_edge(25);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("midrst an", 32'(an), 32'(4'hF));
    check_output("midrst seg", 32'(seg), 32'(7'h7F));
    check_output("midrst tick", 32'(frame_tick), 32'(1'b0));
    edge_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      goto_edge(i);
      check_output($sformatf("midrst tick e%0d", i), 32'(frame_tick), 32'(i == 16));
    end

    // Randomized inputs and occasional resets, checked by the model every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom % 400 == 0);
      if ($urandom % 8 == 0) begin
        for (int n = 0; n < 4; n++)
          qdata[4*n +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
        blink = 4'($urandom);
        lz_en = 1'($urandom);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
